// File: rtl/framebuffer_write_port_if.sv
// rtl/framebuffer_write_port_if.sv - framebuffer RAM write port bundle
interface framebuffer_write_port_if #(
    parameter int ADDR_BITS = 12
);
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [7:0]           mem_data;
    logic                 mem_bank;
    logic                 mem_ready;

    modport master (
        output mem_we,
        output mem_addr,
        output mem_data,
        output mem_bank,
        input  mem_ready
    );

    modport slave (
        input  mem_we,
        input  mem_addr,
        input  mem_data,
        input  mem_bank,
        output mem_ready
    );
endinterface

// File: rtl/framebuffer_write_port.sv
// rtl/framebuffer_write_port.sv - buffered framebuffer byte writer with double-buffered banks
module framebuffer_write_port #(
    parameter int PIXEL_HEIGHT    = 32,
    parameter int PIXEL_WIDTH     = 64,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int FIFO_DEPTH      = 4,
    localparam int FRAME_BYTES    = PIXEL_HEIGHT * PIXEL_WIDTH * BYTES_PER_PIXEL,
    localparam int ADDR_BITS      = $clog2(FRAME_BYTES),
    localparam int ROW_BITS       = $clog2(PIXEL_HEIGHT),
    localparam int COL_BITS       = $clog2(PIXEL_WIDTH),
    localparam int PIX_BITS       = $clog2(BYTES_PER_PIXEL)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ROW_BITS-1:0] row,
    input  logic [COL_BITS-1:0] column,
    input  logic [PIX_BITS-1:0] pixel,
    input  logic [7:0]          data_in,
    input  logic                ram_write_enable,
    input  logic                ram_access_start,
    framebuffer_write_port_if.master mem,
    output logic                display_bank,
    output logic                frame_active,
    output logic                frame_swapped,
    output logic                short_frame,
    output logic                overflow
);
    localparam int PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int CNT_BITS = ADDR_BITS + 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic                 prev_toggle;
    logic                 wr_event;
    logic                 valid1;
    logic [ROW_BITS-1:0]  row1;
    logic [COL_BITS-1:0]  col1;
    logic [PIX_BITS-1:0]  pix1;
    logic [7:0]           data1;
    logic [ADDR_BITS-1:0] lin_addr;
    logic                 valid2;
    logic [ADDR_BITS-1:0] addr2;
    logic                 last2;
    logic [7:0]           data2;

    logic [ADDR_BITS-1:0] fifo_addr [FIFO_DEPTH];
    logic                 fifo_last [FIFO_DEPTH];
    logic [7:0]           fifo_data [FIFO_DEPTH];
    logic [PTR_BITS-1:0]  wr_ptr;
    logic [PTR_BITS-1:0]  rd_ptr;
    logic [PTR_BITS:0]    count;
    logic                 full;
    logic                 empty;
    logic                 pop;
    logic                 push_ok;

    state_t               state;
    logic [CNT_BITS-1:0]  byte_cnt;
    logic [CNT_BITS-1:0]  cnt_next;
    logic                 write_bank;

    assign wr_event = (ram_access_start != prev_toggle) && ram_write_enable;

    // Modular arithmetic at ADDR_BITS equals the full-width result truncated.
    assign lin_addr = (ADDR_BITS'(row1) * ADDR_BITS'(PIXEL_WIDTH) + ADDR_BITS'(col1))
                      * ADDR_BITS'(BYTES_PER_PIXEL) + ADDR_BITS'(pix1);

    assign full    = (count == (PTR_BITS+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign pop     = !empty && mem.mem_ready;
    assign push_ok = valid2 && (!full || pop);

    assign mem.mem_we   = !empty;
    assign mem.mem_addr = empty ? '0 : fifo_addr[rd_ptr];
    assign mem.mem_data = empty ? '0 : fifo_data[rd_ptr];
    assign mem.mem_bank = write_bank;
    assign display_bank = ~write_bank;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_toggle <= 1'b0;
            valid1      <= 1'b0;
            row1        <= '0;
            col1        <= '0;
            pix1        <= '0;
            data1       <= '0;
            valid2      <= 1'b0;
            addr2       <= '0;
            last2       <= 1'b0;
            data2       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
        end else begin
            prev_toggle <= ram_access_start;
            valid1      <= wr_event;
            if (wr_event) begin
                row1  <= row;
                col1  <= column;
                pix1  <= pixel;
                data1 <= data_in;
            end
            valid2 <= valid1;
            if (valid1) begin
                addr2 <= lin_addr;
                // Upstream writes each frame in descending order, so address 0 closes it.
                last2 <= (lin_addr == '0);
                data2 <= data1;
            end
            if (push_ok) begin
                fifo_addr[wr_ptr] <= addr2;
                fifo_last[wr_ptr] <= last2;
                fifo_data[wr_ptr] <= data2;
                wr_ptr            <= wr_ptr + PTR_BITS'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_BITS'(1);
            end
            if (push_ok && !pop) begin
                count <= count + (PTR_BITS+1)'(1);
            end else if (!push_ok && pop) begin
                count <= count - (PTR_BITS+1)'(1);
            end
            if (valid2 && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign cnt_next = (state == IDLE) ? CNT_BITS'(1) : byte_cnt + CNT_BITS'(1);

    // The closing entry still lands in the old bank; the flip applies from the next pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            byte_cnt      <= '0;
            write_bank    <= 1'b0;
            frame_active  <= 1'b0;
            frame_swapped <= 1'b0;
            short_frame   <= 1'b0;
        end else begin
            frame_swapped <= 1'b0;
            short_frame   <= 1'b0;
            if (pop) begin
                if (fifo_last[rd_ptr]) begin
                    if (cnt_next == CNT_BITS'(FRAME_BYTES)) begin
                        write_bank    <= ~write_bank;
                        frame_swapped <= 1'b1;
                    end else begin
                        short_frame <= 1'b1;
                    end
                    state        <= IDLE;
                    byte_cnt     <= '0;
                    frame_active <= 1'b0;
                end else begin
                    state        <= ACTIVE;
                    byte_cnt     <= cnt_next;
                    frame_active <= 1'b1;
                end
            end
        end
    end
endmodule
